// File: rtl/memsrv_pkg.sv
// memsrv_pkg: shared state encoding, ack byte and widths for memory_server
package memsrv_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GET_CMD    = 3'd1,
    WAIT_THIRD = 3'd2,
    MEM_WR     = 3'd3,
    MEM_RD     = 3'd4,
    SEND_RD    = 3'd5,
    SEND_ACK   = 3'd6
  } memsrv_state_t;
  localparam logic [7:0] MEMSRV_ACK_BYTE = 8'h06;
  localparam int MEMSRV_MODE_W = 3;
  localparam int MEMSRV_CNT_W = 15;
endpackage

// File: rtl/memsrv_window_cnt.sv
// memsrv_window_cnt: clear/enable saturating counter with terminal-count compare
module memsrv_window_cnt
  import memsrv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic [MEMSRV_CNT_W-1:0] limit,
  output logic                    tc
);
  logic [MEMSRV_CNT_W-1:0] cnt;
  // clear wins over enable; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign tc = cnt == limit;
endmodule

// File: rtl/uart_sm_rx.sv
// uart_sm_rx: 8N1 UART receiver, one-cycle byte_end pulse per valid byte
module uart_sm_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_end
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  rx_state_t st;
  logic [1:0] sync;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  // synchronise rx, find start bit centre, sample data mid-bit, validate stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= RX_IDLE;
      sync <= 2'b11;
      cnt <= '0;
      bit_idx <= '0;
      byte_out <= '0;
      byte_end <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      byte_end <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          bit_idx <= '0;
          if (!sync[1]) st <= RX_START;
        end
        RX_START:
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            st <= sync[1] ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 16'd1;
        RX_DATA:
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            byte_out <= {sync[1], byte_out[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end else cnt <= cnt + 16'd1;
        default:
          if (cnt == BIT_LAST) begin
            byte_end <= sync[1];
            st <= RX_IDLE;
          end else cnt <= cnt + 16'd1;
      endcase
    end
  end
endmodule

// File: rtl/uart_sm_tx.sv
// uart_sm_tx: 8N1 UART transmitter, starts on rising send_pulse, byte_end after stop bit
module uart_sm_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_pulse,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       byte_end
);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  logic active, send_d;
  logic [8:0] shift;
  logic [15:0] cnt;
  logic [3:0] n;
  // a held send_pulse sends only once: a new byte needs a fresh rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      tx <= 1'b1;
      active <= 1'b0;
      send_d <= 1'b0;
      shift <= '1;
      cnt <= '0;
      n <= '0;
      byte_end <= 1'b0;
    end else begin
      send_d <= send_pulse;
      byte_end <= 1'b0;
      if (!active) begin
        if (send_pulse && !send_d) begin
          active <= 1'b1;
          tx <= 1'b0;
          shift <= {1'b1, byte_in};
          cnt <= '0;
          n <= '0;
        end
      end else if (cnt == BIT_LAST) begin
        cnt <= '0;
        if (n == 4'd9) begin
          active <= 1'b0;
          byte_end <= 1'b1;
          tx <= 1'b1;
        end else begin
          tx <= shift[0];
          shift <= {1'b1, shift[8:1]};
          n <= n + 4'd1;
        end
      end else cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: rtl/memory_server.sv
// memory_server: UART frame to byte-wide memory access responder; MEMSRV_WRITE_ACK_EN adds a write ack byte
module memory_server
  import memsrv_pkg::*;
#(
  parameter int WR_WINDOW = 12500,
  parameter int RESYNC_CYCLES = 25000,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  output logic                     tx,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [7:0]               mem_addr,
  output logic [7:0]               mem_wdata,
  output logic [MEMSRV_MODE_W-1:0] mem_mode,
  input  logic [7:0]               mem_rdata,
  input  logic                     mem_ack,
  output logic                     busy
);
  memsrv_state_t state;
  logic [7:0] addr, wdata, rdata, rx_byte, byte_in;
  logic [2:0] cmd;
  logic rx_end, tx_end, send_pulse, tc, counting;
  logic [MEMSRV_CNT_W-1:0] limit;
  uart_sm_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .reset(reset), .rx(rx), .byte_out(rx_byte), .byte_end(rx_end)
  );
  uart_sm_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk), .reset(reset), .send_pulse(send_pulse), .byte_in(byte_in), .tx(tx), .byte_end(tx_end)
  );
  assign counting = state == GET_CMD || state == WAIT_THIRD;
  assign limit = state == GET_CMD ? MEMSRV_CNT_W'(RESYNC_CYCLES - 1) : MEMSRV_CNT_W'(WR_WINDOW - 1);
  memsrv_window_cnt u_cnt (
    .clk(clk), .reset(reset), .clr(!counting || rx_end || tc), .en(counting), .limit(limit), .tc(tc)
  );
  // frame sequencing; in WAIT_THIRD a byte beats a same-cycle window expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      cmd <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE:
          if (rx_end) begin
            addr <= rx_byte;
            state <= GET_CMD;
          end
        GET_CMD:
          if (rx_end) begin
            cmd <= rx_byte[2:0];
            state <= WAIT_THIRD;
          end else if (tc) state <= IDLE;
        WAIT_THIRD:
          if (rx_end) begin
            wdata <= rx_byte;
            state <= MEM_WR;
          end else if (tc) state <= MEM_RD;
        MEM_WR:
`ifdef MEMSRV_WRITE_ACK_EN
          if (mem_ack) state <= SEND_ACK;
`else
          if (mem_ack) state <= IDLE;
`endif
        MEM_RD:
          if (mem_ack) begin
            rdata <= mem_rdata;
            state <= SEND_RD;
          end
`ifdef MEMSRV_WRITE_ACK_EN
        SEND_ACK: if (tx_end) state <= IDLE;
`endif
        SEND_RD: if (tx_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign mem_req = state == MEM_WR || state == MEM_RD;
  assign mem_we = state == MEM_WR;
  assign mem_addr = addr;
  assign mem_wdata = wdata;
  assign mem_mode = state == MEM_WR ? {1'b0, cmd[1:0]} : cmd;
  assign send_pulse = state == SEND_RD || state == SEND_ACK;
  assign byte_in = state == SEND_ACK ? MEMSRV_ACK_BYTE : rdata;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_memory_server.sv
// tb_memory_server: directed UART frames against memory_server with a small memory responder
module tb_memory_server;
  localparam int CPB = 8;
  localparam int WRW = 120;
  localparam int RSC = 240;
  localparam int RX_DONE = 10 * CPB;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, mem_ack = 1'b0;
  logic tx, mem_req, mem_we, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata = 8'h00;
  logic [2:0] mem_mode;
  int n_chk = 0, n_err = 0, cyc = 0, tx_low = 0;
  int ack_delay = 0, wait_cnt = 0, req_cnt = 0, req_cyc = 0, ack_cyc = 0;
  logic prev_req = 1'b0, cap_we = 1'b0;
  logic [7:0] rd_val = 8'h00, cap_addr = 8'h00, cap_wdata = 8'h00;
  logic [2:0] cap_mode = 3'd0;
  memory_server #(.WR_WINDOW(WRW), .RESYNC_CYCLES(RSC), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!tx) tx_low <= tx_low + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      step(CPB);
    end
  endtask
  task automatic get_byte(output logic [7:0] b, output int start);
    int k;
    b = 8'h00;
    start = 0;
    k = 0;
    while (tx && k < 3000) begin
      step(1);
      k++;
    end
    if (tx) begin
      check("tx_start_timeout", 1, 0);
      return;
    end
    start = cyc;
    step(CPB / 2);
    for (int i = 0; i < 8; i++) begin
      step(CPB);
      b[i] = tx;
    end
    step(CPB);
    check("tx_stop_bit", tx, 1);
  endtask
  task automatic wait_req(input int target);
    int k;
    k = 0;
    while (req_cnt < target && k < 2000) begin
      step(1);
      k++;
    end
    step(1);
    check("req_timeout", req_cnt >= target, 1);
  endtask
  task automatic after_write();
    logic [7:0] b;
    int s, t0;
`ifdef MEMSRV_WRITE_ACK_EN
    get_byte(b, s);
    check("wr_ack_byte", b, 8'h06);
    step(20);
`else
    t0 = tx_low;
    step(150);
    check("wr_silent", tx_low - t0, 0);
`endif
  endtask
  // memory model: acks ack_delay cycles into each request and records the request fields
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!prev_req) begin
          req_cyc = cyc;
          wait_cnt = 0;
        end
        if (wait_cnt == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = rd_val;
          cap_we = mem_we;
          cap_addr = mem_addr;
          cap_wdata = mem_wdata;
          cap_mode = mem_mode;
          ack_cyc = cyc;
          req_cnt++;
        end
        wait_cnt++;
      end
      prev_req = mem_req;
    end
  end
  initial begin
    logic [7:0] b;
    int s, s2, r0;
    step(5);
    check("rst_tx", tx, 1);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_mode", mem_mode, 0);
    reset = 1'b0;
    step(5);
    // write 3C/01/A5, ack in first request cycle
    ack_delay = 0;
    send_byte(8'h3C);
    send_byte(8'h01);
    s = cyc;
    send_byte(8'hA5);
    wait_req(1);
    check("wr_we", cap_we, 1);
    check("wr_addr", cap_addr, 8'h3C);
    check("wr_wdata", cap_wdata, 8'hA5);
    check("wr_mode", cap_mode, 3'b001);
    check("wr_latency", req_cyc - s, RX_DONE);
    after_write();
    check("wr_count", req_cnt, 1);
    check("wr_idle", busy, 0);
    // read 10/04, ack after 3 cycles with 7E
    ack_delay = 3;
    rd_val = 8'h7E;
    send_byte(8'h10);
    s2 = cyc;
    send_byte(8'h04);
    wait_req(2);
    check("rd_we", cap_we, 0);
    check("rd_addr", cap_addr, 8'h10);
    check("rd_mode", cap_mode, 3'b100);
    check("rd_latency", req_cyc - s2, RX_DONE + WRW);
    get_byte(b, s);
    check("rd_byte", b, 8'h7E);
    check("rd_tx_start", s - ack_cyc, 2);
    step(20);
    check("rd_idle", busy, 0);
    // window race: third byte completes in the expiry cycle, cmd upper bits ignored
    ack_delay = 1;
    r0 = req_cnt;
    send_byte(8'h08);
    s2 = cyc;
    send_byte(8'hF2);
    step(s2 + WRW - cyc);
    send_byte(8'hC3);
    wait_req(r0 + 1);
    check("race_we", cap_we, 1);
    check("race_wdata", cap_wdata, 8'hC3);
    check("race_mode", cap_mode, 3'b010);
    after_write();
    step(150);
    check("race_count", req_cnt - r0, 1);
    // resync: lone byte times out, then a normal write
    r0 = req_cnt;
    send_byte(8'h55);
    step(2);
    check("resync_busy", busy, 1);
    step(RSC - 12);
    check("resync_still_busy", busy, 1);
    step(30);
    check("resync_idle", busy, 0);
    check("resync_noreq", req_cnt - r0, 0);
    send_byte(8'h20);
    send_byte(8'h02);
    send_byte(8'h11);
    wait_req(r0 + 1);
    check("resync_addr", cap_addr, 8'h20);
    check("resync_wdata", cap_wdata, 8'h11);
    check("resync_we", cap_we, 1);
    after_write();
    // MemWrite 00 still reaches memory with mode 000
    send_byte(8'h7F);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_req(r0 + 2);
    check("nop_mode", cap_mode, 3'b000);
    check("nop_we", cap_we, 1);
    after_write();
    // reset during SEND_RD, then a clean read
    rd_val = 8'h99;
    send_byte(8'h30);
    send_byte(8'h02);
    wait_req(r0 + 3);
    s = 0;
    while (tx && s < 100) begin
      step(1);
      s++;
    end
    check("mid_tx_active", tx, 0);
    step(3 * CPB);
    reset = 1'b1;
    step(1);
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_addr", mem_addr, 0);
    reset = 1'b0;
    step(10);
    rd_val = 8'h5A;
    send_byte(8'h44);
    send_byte(8'h03);
    wait_req(r0 + 4);
    check("post_rst_addr", cap_addr, 8'h44);
    check("post_rst_mode", cap_mode, 3'b011);
    get_byte(b, s);
    check("post_rst_byte", b, 8'h5A);
    step(20);
    // write 01/03/FF, with the ack byte when enabled
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'hFF);
    wait_req(r0 + 5);
    check("wack_addr", cap_addr, 8'h01);
    check("wack_wdata", cap_wdata, 8'hFF);
    check("wack_mode", cap_mode, 3'b011);
    after_write();
    check("final_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
